// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between the SoC and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       error;
    modport master (output tx_data, tx_start, input busy, done, error);
    modport slave (input tx_data, tx_start, output busy, done, error);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, start, data/odd parity/stop, ACK check).
// Define PS2_TX_RETRY_EN to relaunch a NACK/timeout up to twice before reporting error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int CMAX = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE, FAIL} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [9:0] shift, shift_n;
    logic [3:0] bit_cnt, bit_n;
    logic busy, busy_n, done, done_n, error, error_n, clk_oe_n, data_oe_n;
    logic [1:0] clk_s, data_s;
    logic clk_prev, fall, fail;
`ifdef PS2_TX_RETRY_EN
    logic [7:0] data_q, data_n;
    logic [1:0] retry, retry_n;
`endif
    assign fall = clk_prev & ~clk_s[1];
    assign tx.busy = busy;
    assign tx.done = done;
    assign tx.error = error;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            clk_s       <= 2'b11;
            data_s      <= 2'b11;
            clk_prev    <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            shift       <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            clk_s       <= {clk_s[0], ps2_clk_i};
            data_s      <= {data_s[0], ps2_data_i};
            clk_prev    <= clk_s[1];
            state       <= state_n;
            cnt         <= cnt_n;
            shift       <= shift_n;
            bit_cnt     <= bit_n;
            busy        <= busy_n;
            done        <= done_n;
            error       <= error_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
        end
`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            data_q <= '0;
            retry  <= '0;
        end else begin
            data_q <= data_n;
            retry  <= retry_n;
        end
`endif
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shift_n   = shift;
        bit_n     = bit_cnt;
        busy_n    = busy;
        done_n    = 1'b0;
        error_n   = 1'b0;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        data_n    = data_q;
        retry_n   = retry;
`endif
        case (state)
            IDLE: if (tx.tx_start) begin
                state_n  = INHIBIT;
                cnt_n    = '0;
                bit_n    = '0;
                busy_n   = 1'b1;
                clk_oe_n = 1'b1;
                shift_n  = {1'b1, ~^tx.tx_data, tx.tx_data};
`ifdef PS2_TX_RETRY_EN
                data_n   = tx.tx_data;
                retry_n  = '0;
`endif
            end
            INHIBIT: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    state_n   = START;
                    data_oe_n = 1'b1;
                end
            end
            START: begin
                state_n  = SEND;
                clk_oe_n = 1'b0;
                cnt_n    = '0;
            end
            SEND, ACK, WAIT_IDLE: begin
                cnt_n = cnt + 1'b1;
                // Timeout wins over an edge arriving in the same cycle
                if (cnt == CW'(TIMEOUT_CYCLES - 1))
                    fail = 1'b1;
                else if (state == SEND && fall) begin
                    data_oe_n = ~shift[0];
                    shift_n   = {1'b0, shift[9:1]};
                    bit_n     = bit_cnt + 4'd1;
                    state_n   = bit_cnt == 4'd9 ? ACK : SEND;
                end else if (state == ACK && fall) begin
                    fail    = data_s[1];
                    state_n = data_s[1] ? ACK : WAIT_IDLE;
                end else if (state == WAIT_IDLE && clk_s[1] && data_s[1]) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            FAIL: begin
                state_n   = IDLE;
                error_n   = 1'b1;
                busy_n    = 1'b0;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
        if (fail) begin
`ifdef PS2_TX_RETRY_EN
            if (retry != 2'd2) begin
                retry_n   = retry + 2'd1;
                state_n   = INHIBIT;
                cnt_n     = '0;
                bit_n     = '0;
                clk_oe_n  = 1'b1;
                data_oe_n = 1'b0;
                shift_n   = {1'b1, ~^data_q, data_q};
            end else
`endif
            begin
                state_n   = FAIL;
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
            end
        end
    end
endmodule
